serial_a_paralelo: RTL and testbench
====================================

# serial_a_paralelo

Serial-to-parallel receiver for the PCIe physical-layer lane, the receive-side counterpart of `paralelo_a_serial`. It samples one serial bit per `clk32f` cycle, hunts for the COM symbol to find byte boundaries, and declares the lane active after a run of consecutive COMs. Once active, it delivers each non-COM byte on an 8-bit parallel output with a valid flag held for the full byte period. It sits between the serial line and the byte-wide logic of the lane (`clk4f` / `clk` domains sample its held outputs).

## Interface
Parameters:
- `COM`, 8'hBC, alignment/idle symbol
- `COM_NEEDED`, 4, consecutive COMs required to go active (≥2)
- `MAX_GAP`, 16, consecutive non-COM bytes tolerated while active (used only with `S2P_LOSS_DETECT_EN`)

Ports:
- `clk32f`  input  1  bit clock; all logic on rising edge
- `reset`  input  1  asynchronous, active-high
- `in`  input  1  serial data, MSB first
- `out`  output  8  last received data byte
- `valid_out`  output  1  `out` holds a fresh data byte for the current byte period
- `active`  output  1  lane byte-aligned and locked

## Operation
- Shift register `sr[7:0]`: every edge `sr <= {sr[6:0], in}`. Candidate byte `b = {sr[6:0], in}`.
- Bit counter `cnt` (3 bits) increments every edge and wraps 7→0; byte boundary = edge where `cnt == 7`.
- COM counter `bc_cnt`, width `$clog2(COM_NEEDED+1)`.
- States:
  - HUNT: `b` checked every edge regardless of `cnt`. On `b == COM`: `cnt <= 0`, `bc_cnt <= 1`, → SYNC.
  - SYNC: at byte boundary, if `b == COM`, `bc_cnt++`; when the increment reaches `COM_NEEDED` → ACTIVE, `active <= 1`. If `b != COM` → HUNT, `bc_cnt <= 0`. No output updates.
  - ACTIVE: at byte boundary, if `b != COM`: `out <= b`, `valid_out <= 1`. If `b == COM`: `valid_out <= 0`, `out` holds. Between boundaries, `out`/`valid_out` hold.
- Without loss detect, ACTIVE is left only by `reset`.

## Timing
- Reset values: `out = 8'h00`, `valid_out = 0`, `active = 0`, state HUNT, `sr = 0`, `cnt = 0`, `bc_cnt = 0`, gap counter 0.
- `reset` clears all state immediately, including mid-byte or mid-lock. After release, the first edge samples into HUNT.
- Latency: `out`/`valid_out` update on the same edge that samples the byte's LSB. They are visible after that edge, and one byte is held for exactly 8 `clk32f` cycles.
- `active` rises on the edge sampling the LSB of the `COM_NEEDED`-th COM. It is 0 for that COM byte period, so no output is produced.
- A COM boundary match in HUNT overrides any prior `cnt` value, so arbitrary bit slip is absorbed.
- A COM pattern straddling byte boundaries in SYNC/ACTIVE is ignored; only aligned bytes are compared.

## Configuration
- `S2P_LOSS_DETECT_EN` defined:
  - ACTIVE keeps a gap counter, width `$clog2(MAX_GAP+1)`. It clears on each boundary COM and increments on each boundary data byte.
  - On the boundary where it reaches `MAX_GAP`, the byte is dropped: `valid_out <= 0`, `active <= 0`, `bc_cnt <= 0`, gap cleared, → HUNT. `out` holds.
- Not defined: no gap counter. ACTIVE is sticky until `reset`, and any run length of data is accepted.

## Test plan
- Reset mid-stream: assert `reset` while ACTIVE with `out = 8'hA5` → `out = 00`, `valid_out = 0`, `active = 0` with no clock edge; relock requires 4 COMs.
- Lock with slip: 3 filler bits 1,0,1, then 4×8'hBC MSB first → `active` rises on edge 35 after reset release, `valid_out` stays 0.
- Data: after lock, send 8'hA5, 8'h3C, 8'hBC → `out = A5`, `valid_out = 1` for 8 cycles; then `out = 3C` for 8 cycles; then `valid_out = 0` with `out = 3C`.
- Broken sync: BC, BC, 8'h55, then BC ×4 → `active` stays 0 through 8'h55 and rises only at the end of the 4th subsequent BC.
- Loss detect (macro on, `MAX_GAP = 16`): after lock, 16 data bytes with no COM → bytes 1–15 output; at the 16th boundary `active = 0`, `valid_out = 0`. Macro off: all 16 output, `active` stays 1.

Source files
------------

// File: rtl/serial_a_paralelo_if.sv
// Serial-to-parallel lane bus: the serial input plus the held byte, its
// valid flag and the lane-lock indication.
interface serial_a_paralelo_if;
    logic       in;
    logic [7:0] out;
    logic       valid_out;
    logic       active;

    // Line side: drives serial bits, observes the recovered bytes.
    modport master (output in, input out, valid_out, active);
    // Receiver side.
    modport slave  (input in, output out, valid_out, active);
endinterface

// File: rtl/serial_a_paralelo.sv
// serial_a_paralelo: PCIe lane serial-to-parallel receiver.
// Hunts for the COM symbol on every bit, confirms byte alignment with
// COM_NEEDED aligned COMs, then delivers each aligned non-COM byte with a
// valid flag held for the whole byte period.
// Optional macro S2P_LOSS_DETECT_EN: drop lock after MAX_GAP consecutive
// aligned data bytes without a COM.
module serial_a_paralelo #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         COM_NEEDED = 4,
    parameter int         MAX_GAP    = 16
) (
    input  logic              clk32f,
    input  logic              reset,
    serial_a_paralelo_if.slave bus
);
    localparam int BC_W = $clog2(COM_NEEDED + 1);

    typedef enum logic [1:0] {HUNT, SYNC, ACTIVE} state_t;

    state_t          state_reg, state_next;
    logic [7:0]      sr_reg, sr_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic [BC_W-1:0] bc_cnt_reg, bc_cnt_next;
    logic [7:0]      out_reg, out_next;
    logic            valid_reg, valid_next;
    logic            active_reg, active_next;

    logic [7:0]      b;
    logic            is_com;
    logic            boundary;
    logic [BC_W-1:0] bc_inc;

    assign b        = {sr_reg[6:0], bus.in};
    assign is_com   = (b == COM);
    assign boundary = (cnt_reg == 3'd7);
    assign bc_inc   = bc_cnt_reg + BC_W'(1);

`ifdef S2P_LOSS_DETECT_EN
    localparam int GAP_W = $clog2(MAX_GAP + 1);
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [GAP_W-1:0] gap_inc;
    assign gap_inc = gap_reg + GAP_W'(1);

    // Gap counter register, only present with loss detection.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) gap_reg <= '0;
        else       gap_reg <= gap_next;
    end
`else
    // MAX_GAP has no effect when loss detection is compiled out.
    logic unused_gap_cfg;
    assign unused_gap_cfg = (MAX_GAP != 0);
`endif

    // The MSB of the shift register only matters as history; b already
    // contains everything the decoder needs.
    logic unused_sr_msb;
    assign unused_sr_msb = sr_reg[7];

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state_reg  <= HUNT;
            sr_reg     <= 8'h00;
            cnt_reg    <= 3'd0;
            bc_cnt_reg <= '0;
            out_reg    <= 8'h00;
            valid_reg  <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sr_reg     <= sr_next;
            cnt_reg    <= cnt_next;
            bc_cnt_reg <= bc_cnt_next;
            out_reg    <= out_next;
            valid_reg  <= valid_next;
            active_reg <= active_next;
        end
    end

    // Next-state and output decode: hunt on every bit, compare only aligned
    // bytes once a COM has fixed the boundary.
    always_comb begin
        state_next  = state_reg;
        sr_next     = b;
        cnt_next    = cnt_reg + 3'd1;
        bc_cnt_next = bc_cnt_reg;
        out_next    = out_reg;
        valid_next  = valid_reg;
        active_next = active_reg;
`ifdef S2P_LOSS_DETECT_EN
        gap_next    = gap_reg;
`endif
        case (state_reg)
            HUNT: begin
                if (is_com) begin
                    // Realign: the byte just completed ends here.
                    cnt_next    = 3'd0;
                    bc_cnt_next = BC_W'(1);
                    state_next  = SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_com) begin
                        bc_cnt_next = bc_inc;
                        if (bc_inc == BC_W'(COM_NEEDED)) begin
                            state_next  = ACTIVE;
                            active_next = 1'b1;
                        end
                    end else begin
                        bc_cnt_next = '0;
                        state_next  = HUNT;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (is_com) begin
                        valid_next = 1'b0;
`ifdef S2P_LOSS_DETECT_EN
                        gap_next   = '0;
`endif
                    end else begin
`ifdef S2P_LOSS_DETECT_EN
                        if (gap_inc == GAP_W'(MAX_GAP)) begin
                            // Too long without a COM: drop this byte and the lock.
                            valid_next  = 1'b0;
                            active_next = 1'b0;
                            bc_cnt_next = '0;
                            gap_next    = '0;
                            state_next  = HUNT;
                        end else begin
                            gap_next   = gap_inc;
                            out_next   = b;
                            valid_next = 1'b1;
                        end
`else
                        out_next   = b;
                        valid_next = 1'b1;
`endif
                    end
                end
            end
            default: state_next = HUNT;
        endcase
    end

    assign bus.out       = out_reg;
    assign bus.valid_out = valid_reg;
    assign bus.active    = active_reg;
endmodule

// File: tb/tb_serial_a_paralelo.sv
// Directed testbench for serial_a_paralelo (default parameters).
// Covers reset, lock with bit slip, data hold, async reset mid-stream,
// the long data run (with or without S2P_LOSS_DETECT_EN) and broken sync.
module tb_serial_a_paralelo;
    logic clk32f = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;

    serial_a_paralelo_if bus_if ();

    serial_a_paralelo dut (
        .clk32f (clk32f),
        .reset  (reset),
        .bus    (bus_if)
    );

    always #5 clk32f = ~clk32f;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    // Drive one bit; return 1 ns after the edge that sampled it.
    task automatic send_bit(input logic v);
        bus_if.in = v;
        @(posedge clk32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] o,
                              input logic v, input logic a);
        check({tag, ".out"}, bus_if.out, o);
        check({tag, ".valid"}, {7'd0, bus_if.valid_out}, {7'd0, v});
        check({tag, ".active"}, {7'd0, bus_if.active}, {7'd0, a});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] slip;
        bus_if.in = 1'b0;
        repeat (3) @(posedge clk32f);
        #1;
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        // Lock with 3-bit slip: active rises on edge 35.
        slip = 8'b1010_0000;
        for (int i = 7; i > 4; i--) send_bit(slip[i]);
        repeat (3) send_byte(8'hBC);
        d = 8'hBC;
        for (int i = 7; i > 0; i--) send_bit(d[i]);
        check_outs("lock_e34", 8'h00, 1'b0, 1'b0);
        send_bit(d[0]);
        check_outs("lock_e35", 8'h00, 1'b0, 1'b1);

        // Data: A5 held 8 cycles, then 3C, then COM clears valid.
        send_byte(8'hA5);
        check_outs("data_a5", 8'hA5, 1'b1, 1'b1);
        d = 8'h3C;
        for (int i = 7; i > 0; i--) begin
            send_bit(d[i]);
            check($sformatf("hold_a5_%0d", 7 - i), bus_if.out, 8'hA5);
        end
        send_bit(d[0]);
        check_outs("data_3c", 8'h3C, 1'b1, 1'b1);
        send_byte(8'hBC);
        check_outs("com_idle", 8'h3C, 1'b0, 1'b1);

        // Reset mid-byte while holding A5: outputs clear with no edge.
        send_byte(8'hA5);
        check_outs("pre_rst", 8'hA5, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        #1;
        check_outs("async_rst", 8'h00, 1'b0, 1'b0);
        #1;
        reset = 1'b0;

        // Relock with 4 aligned COMs.
        repeat (3) send_byte(8'hBC);
        check_outs("relock_3", 8'h00, 1'b0, 1'b0);
        send_byte(8'hBC);
        check_outs("relock_4", 8'h00, 1'b0, 1'b1);

        // 16 data bytes without COM; first two straddle a COM pattern.
        for (int i = 0; i < 16; i++) begin
            d = (i == 0) ? 8'h0B : (i == 1) ? 8'hC0 : 8'h20 + 8'(i);
            send_byte(d);
            if (i < 15) begin
                check_outs($sformatf("run_%0d", i + 1), d, 1'b1, 1'b1);
            end else begin
`ifdef S2P_LOSS_DETECT_EN
                check_outs("run_16_loss", 8'h2E, 1'b0, 1'b0);
`else
                check_outs("run_16", 8'h2F, 1'b1, 1'b1);
`endif
            end
        end

        // Broken sync: BC BC 55 drops back to hunt; 4 more BC lock.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h55);
        check_outs("broken_55", 8'h00, 1'b0, 1'b0);
        repeat (3) send_byte(8'hBC);
        check_outs("broken_bc3", 8'h00, 1'b0, 1'b0);
        send_byte(8'hBC);
        check_outs("broken_bc4", 8'h00, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
